// File: rtl/display_dynamic_scanner_pkg.sv
// Shared definitions for the scanned 7-segment display driver.
package display_dynamic_scanner_pkg;

  // Active-low segment bus value with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Per-slot phase: selects held off first, then the digit is shown.
  typedef enum logic {BLANK, SHOW} state_t;

  // The decoder produces active-high segments; the shared bus is active-low.
  function automatic logic [6:0] toActiveLow(input logic [6:0] segHigh);
    return ~segHigh;
  endfunction

endpackage

// File: rtl/display_static_digit.sv
// Nibble to 7-segment decoder, active-high segments, bit 0 = a ... bit 6 = g.
module display_static_digit (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Hex glyph lookup, lowercase b and d so they differ from 8 and 0.
  always_comb begin
    o_seg = 7'h00;
    case (i_nibble)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_dynamic_scanner.sv
// Time-multiplexed common-anode 7-segment driver. New values are staged on
// load and copied into a shadow set only at frame boundaries so a frame never
// mixes old and new digits. Every output is registered.
module display_dynamic_scanner
  import display_dynamic_scanner_pkg::*;
#(
  parameter int W_DIGITS     = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [4*W_DIGITS-1:0] i_number,
  input  logic [W_DIGITS-1:0]   i_dots,
  input  logic [W_DIGITS-1:0]   i_digit_en,
  input  logic                  i_load,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [W_DIGITS-1:0]   o_digit_sel,
  output logic                  o_frame_start
);

  localparam int W_PRESC = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int W_IDX   = (W_DIGITS > 1) ? $clog2(W_DIGITS) : 1;
  localparam logic [W_PRESC-1:0] PRESC_LAST = W_PRESC'(REFRESH_DIV - 1);
  localparam logic [W_PRESC-1:0] BLANK_END  = W_PRESC'(BLANK_CYCLES);
  localparam logic [W_IDX-1:0]   IDX_LAST   = W_IDX'(W_DIGITS - 1);

  logic [W_PRESC-1:0]    r_presc, w_nextPresc;
  logic [W_IDX-1:0]      r_idx, w_nextIdx;
  state_t                r_state, w_nextState;
  logic                  r_first;
  logic                  w_boundary;
  logic [4*W_DIGITS-1:0] r_stageNum, r_shadowNum;
  logic [W_DIGITS-1:0]   r_stageDots, r_shadowDots;
  logic [W_DIGITS-1:0]   r_stageEn, r_shadowEn;
  logic                  r_pending;
  logic [3:0]            w_nibble;
  logic [6:0]            w_segHigh;
  logic [6:0]            w_segNext;
  logic                  w_dpNext;
  logic [W_DIGITS-1:0]   w_selNext;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [W_DIGITS-1:0]   r_sel;
  logic                  r_frameStart;

  // A frame ends on the last cycle of the last slot; the first cycle after
  // reset also counts so a load there lands directly in the shadow set.
  assign w_boundary = ((r_presc == PRESC_LAST) && (r_idx == IDX_LAST)) || r_first;

  // Next prescaler/index and the slot phase they imply.
  always_comb begin
    w_nextPresc = r_presc + 1'b1;
    w_nextIdx   = r_idx;
    if (r_presc == PRESC_LAST) begin
      w_nextPresc = '0;
      w_nextIdx   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
    w_nextState = (w_nextPresc < BLANK_END) ? BLANK : SHOW;
  end

  // Scan position and slot phase registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_state <= BLANK;
      r_first <= 1'b1;
    end else begin
      r_presc <= w_nextPresc;
      r_idx   <= w_nextIdx;
      r_state <= w_nextState;
      r_first <= 1'b0;
    end
  end

  // Staging takes every load; the shadow set only changes at a frame boundary.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stageNum   <= '0;
      r_stageDots  <= '0;
      r_stageEn    <= '0;
      r_shadowNum  <= '0;
      r_shadowDots <= '0;
      r_shadowEn   <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (i_load) begin
        r_stageNum  <= i_number;
        r_stageDots <= i_dots;
        r_stageEn   <= i_digit_en;
      end
      if (w_boundary) begin
        if (i_load) begin
          r_shadowNum  <= i_number;
          r_shadowDots <= i_dots;
          r_shadowEn   <= i_digit_en;
        end else if (r_pending) begin
          r_shadowNum  <= r_stageNum;
          r_shadowDots <= r_stageDots;
          r_shadowEn   <= r_stageEn;
        end
        r_pending <= 1'b0;
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_nibble = r_shadowNum[{r_idx, 2'b00} +: 4];

  display_static_digit u_digit (
    .i_nibble (w_nibble),
    .o_seg    (w_segHigh)
  );

  // Pin values for the current slot phase; disabled digits keep their select off.
  always_comb begin
    w_segNext = SEG_OFF;
    w_dpNext  = 1'b1;
    w_selNext = '1;
    if (r_state == SHOW) begin
      w_segNext = toActiveLow(w_segHigh);
      w_dpNext  = ~r_shadowDots[r_idx];
      if (r_shadowEn[r_idx]) begin
        w_selNext[r_idx] = 1'b0;
      end
    end
  end

  // Output registers; frame_start lines up with the first BLANK cycle of slot 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_sel        <= '1;
      r_frameStart <= 1'b0;
    end else begin
      r_seg        <= w_segNext;
      r_dp         <= w_dpNext;
      r_sel        <= w_selNext;
      r_frameStart <= (r_presc == '0) && (r_idx == '0);
    end
  end

  assign o_seg         = r_seg;
  assign o_dp          = r_dp;
  assign o_digit_sel   = r_sel;
  assign o_frame_start = r_frameStart;

endmodule
